// File: rtl/i2c_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_arbiter
//
// Shares one register-style I2C master between two requesters. An idle
// request is granted round-robin, the winner's command is latched and
// handed to the master with a one-cycle start strobe, and completion (or
// timeout) is reported back to the winner with a one-cycle response pulse.
//
// Handshake semantics (all signals sampled on the rising edge of clk):
//   - A requester raises req[i] with its command fields stable and keeps it
//     up until it sees gnt[i]. req is only looked at while the arbiter is
//     idle, so a request that is withdrawn before being granted never
//     produces a transaction.
//   - gnt[i] is a one-cycle pulse in the cycle the command is issued to the
//     master; the requester may change its fields afterwards.
//   - rsp_valid[i] is a one-cycle pulse; rsp_rdata/rsp_err are valid with it
//     and keep their value until the next response.
//   - m_start is a one-cycle strobe; the command fields stay stable until
//     the next grant.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req, req_rw        per-requester request and direction (1 = read)
//   req_slave_addr     7-bit slave address per requester ([7i+6:7i])
//   req_reg_addr       7-bit register address per requester ([7i+6:7i])
//   req_wdata          8-bit write data per requester ([8i+7:8i])
//   gnt                one-cycle accept pulse per requester
//   rsp_valid          one-cycle completion pulse per requester
//   rsp_rdata, rsp_err read data / timeout flag, held until next response
//   m_start            start strobe to the I2C master
//   m_read_write, m_slave_addr, m_reg_addr, m_data_in  command to master
//   m_busy, m_done, m_data_out                         status from master
//   state_ind          current FSM state (IDLE=0 .. RESP=4)
// ---------------------------------------------------------------------------
module i2c_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  req_rw,
    input  logic [13:0] req_slave_addr,
    input  logic [13:0] req_reg_addr,
    input  logic [15:0] req_wdata,
    output logic [1:0]  gnt,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        m_start,
    output logic        m_read_write,
    output logic [6:0]  m_slave_addr,
    output logic [6:0]  m_reg_addr,
    output logic [7:0]  m_data_in,
    input  logic        m_busy,
    input  logic        m_done,
    input  logic [7:0]  m_data_out,
    output logic [2:0]  state_ind
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_t;

    // Last wait-cycle count before the transaction is abandoned.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic        winner;
    logic        last_served;
    logic [15:0] cnt;
    logic        pick;

    // Round-robin choice: on contention the requester that was not served
    // last wins; a lone requester always wins.
    always_comb begin
        pick = req[1];
        if (req == 2'b11) begin
            pick = ~last_served;
        end
    end

    assign state_ind = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            winner       <= 1'b0;
            last_served  <= 1'b1;
            cnt          <= 16'd0;
            gnt          <= 2'b00;
            rsp_valid    <= 2'b00;
            rsp_rdata    <= 8'h00;
            rsp_err      <= 1'b0;
            m_start      <= 1'b0;
            m_read_write <= 1'b0;
            m_slave_addr <= 7'd0;
            m_reg_addr   <= 7'd0;
            m_data_in    <= 8'h00;
        end else begin
            gnt       <= 2'b00;
            rsp_valid <= 2'b00;
            m_start   <= 1'b0;

            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        winner       <= pick;
                        gnt          <= pick ? 2'b10 : 2'b01;
                        // Raised on entry so the strobe is high exactly
                        // during the ISSUE cycle.
                        m_start      <= 1'b1;
                        m_read_write <= pick ? req_rw[1] : req_rw[0];
                        m_slave_addr <= pick ? req_slave_addr[13:7] : req_slave_addr[6:0];
                        m_reg_addr   <= pick ? req_reg_addr[13:7] : req_reg_addr[6:0];
                        m_data_in    <= pick ? req_wdata[15:8] : req_wdata[7:0];
                        state        <= ISSUE;
                    end
                end

                ISSUE: begin
                    cnt   <= 16'd0;
                    state <= WAIT_BUSY;
                end

                WAIT_BUSY: begin
                    // A master that finishes before ever showing busy is
                    // accepted as a completed transaction.
                    if (m_done && !m_busy) begin
                        rsp_rdata <= m_read_write ? m_data_out : 8'h00;
                        rsp_err   <= 1'b0;
                        rsp_valid <= winner ? 2'b10 : 2'b01;
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_rdata <= 8'h00;
                        rsp_err   <= 1'b1;
                        rsp_valid <= winner ? 2'b10 : 2'b01;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (m_busy) begin
                            state <= WAIT_DONE;
                        end
                    end
                end

                WAIT_DONE: begin
                    // Done is checked first so it wins over a coincident
                    // timeout.
                    if (m_done) begin
                        rsp_rdata <= m_read_write ? m_data_out : 8'h00;
                        rsp_err   <= 1'b0;
                        rsp_valid <= winner ? 2'b10 : 2'b01;
                        state     <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        rsp_rdata <= 8'h00;
                        rsp_err   <= 1'b1;
                        rsp_valid <= winner ? 2'b10 : 2'b01;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                RESP: begin
                    last_served <= winner;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: max cycles from m_start to m_done before abort (legal range 4..65535).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  2  per-requester transaction request, bit i = requester i.
REQ-005 SHALL have port req_rw  input  2  per-requester direction, 1 = read, 0 = write.
REQ-006 SHALL have port req_slave_addr  input  14  7-bit slave address per requester, requester i at [7i+6:7i].
REQ-007 SHALL have port req_reg_addr  input  14  7-bit register address per requester, same packing.
REQ-008 SHALL have port req_wdata  input  16  8-bit write data per requester, requester i at [8i+7:8i].
REQ-009 SHALL have port gnt  output  2  one-cycle accept pulse, bit i = requester i.
REQ-010 SHALL have port rsp_valid  output  2  one-cycle completion pulse, bit i = requester i.
REQ-011 SHALL have port rsp_rdata  output  8  read data, valid with rsp_valid.
REQ-012 SHALL have port rsp_err  output  1  timeout flag, valid with rsp_valid.
REQ-013 SHALL have port m_start  output  1  start strobe to I2C master.
REQ-014 SHALL have port m_read_write  output  1  direction to master.
REQ-015 SHALL have port m_slave_addr  output  7  slave address to master.
REQ-016 SHALL have port m_reg_addr  output  7  register address to master.
REQ-017 SHALL have port m_data_in  output  8  write data to master.
REQ-018 SHALL have port m_busy  input  1  master busy flag.
REQ-019 SHALL have port m_done  input  1  master completion flag.
REQ-020 SHALL have port m_data_out  input  8  master read data.
REQ-021 SHALL have port state_ind  output  3  current FSM state encoding.

Function
REQ-022 SHALL implement FSM IDLE(0) -> ISSUE(1) -> WAIT_BUSY(2) -> WAIT_DONE(3) -> RESP(4) -> IDLE; state_ind = state.
REQ-023 IDLE, req != 0: SHALL select winner, latch its rw/slave_addr/reg_addr/wdata into m_* regs, pulse gnt[winner] that cycle's registered output, go ISSUE.
REQ-024 Arbitration SHALL be round-robin: both requesting -> grant requester != last_served; single requester -> grant it.
REQ-025 ISSUE: m_start SHALL be 1 for exactly one cycle; next state WAIT_BUSY; m_start 0 in all other states.
REQ-026 m_read_write/m_slave_addr/m_reg_addr/m_data_in SHALL hold latched values from ISSUE through WAIT_DONE, unaffected by req-side changes.
REQ-027 WAIT_BUSY: m_busy=1 -> WAIT_DONE; m_done=1 with m_busy=0 SHALL also -> RESP (fast completion).
REQ-028 Timeout counter (16-bit) SHALL clear in ISSUE, increment each cycle in WAIT_BUSY/WAIT_DONE; reaching TIMEOUT-1 -> RESP with err=1.
REQ-029 WAIT_DONE: m_done=1 -> capture m_data_out (read) or 0x00 (write) into rsp_rdata, err=0, -> RESP.
REQ-030 m_done and timeout in same cycle: done SHALL win, err=0.
REQ-031 RESP: rsp_valid[winner]=1 one cycle; rsp_rdata/rsp_err stable that cycle; last_served <= winner; -> IDLE.
REQ-032 rsp_rdata and rsp_err SHALL hold value until next RESP; on timeout rsp_rdata = 0x00.
REQ-033 req sampled only in IDLE; requests arriving during a transaction SHALL wait; req dropped before grant SHALL cause no transaction.
REQ-034 Minimum spacing: next gnt no earlier than the cycle after RESP (IDLE cycle required).

Reset
REQ-035 rst=1 SHALL force state IDLE; gnt, rsp_valid, m_start, rsp_err = 0; rsp_rdata, m_* fields = 0; counter 0; last_served = 1 (requester 0 first).
REQ-036 rst mid-transaction SHALL abort without rsp_valid; m_start never asserted during reset.

Verification
REQ-037 Read: req=01, req_rw=01, slave 0x48, reg 0x05; model busy 3 cycles, done, data_out 0xA5 -> one m_start, gnt=01, rsp_valid=01, rsp_rdata=0xA5, rsp_err=0.
REQ-038 Write: req=10, req_rw=00, wdata[15:8]=0x3C -> m_data_in=0x3C, m_read_write=0, rsp_valid=10, rsp_rdata=0x00.
REQ-039 Contention: req=11 held for 4 transactions after reset -> grant order 0,1,0,1.
REQ-040 Timeout: TIMEOUT=8, master never asserts done -> rsp_valid after 8 wait cycles, rsp_err=1, rsp_rdata=0x00.
REQ-041 Boundary: m_done on same cycle counter hits TIMEOUT-1 -> rsp_err=0, data captured.
REQ-042 Reset in WAIT_DONE -> state_ind=0, no rsp_valid, next req=01 granted normally.
